// File: rtl/lt24_panel_receiver_if.sv
// LT24 8080-style bus plus addressed-pixel output stream.
// Slave = panel receiver; master = bus initiator / pixel consumer.
interface lt24_panel_receiver_if;
    logic        lt24_cs;
    logic        lt24_rs;
    logic        lt24_wr;
    logic        lt24_rd;
    logic [15:0] lt24_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;

    modport master (
        output lt24_cs, lt24_rs, lt24_wr, lt24_rd, lt24_data, pix_ready,
        input  pix_valid, pix_x, pix_y, pix_data
    );

    modport slave (
        input  lt24_cs, lt24_rs, lt24_wr, lt24_rd, lt24_data, pix_ready,
        output pix_valid, pix_x, pix_y, pix_data
    );
endinterface

// File: rtl/lt24_panel_receiver.sv
// Decodes ILI9341 window/memory-write commands and emits addressed pixels.
// Latency: wr edge sampled at k -> push at k+2 -> pix_valid after k+3.
// Backpressure: FIFO_DEPTH-entry FIFO; pushes while full are dropped (sticky overflow).
module lt24_panel_receiver #(
    parameter int unsigned H_RES      = 240,
    parameter int unsigned V_RES      = 320,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    lt24_panel_receiver_if.slave        bus,
    output logic                        o_ramwr_active,
    output logic                        o_overflow,
    output logic                        o_cmd_err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [15:0] LP_H  = 16'(H_RES);
    localparam logic [15:0] LP_V  = 16'(V_RES);
    localparam logic [8:0]  LP_EC = 9'(H_RES - 1);
    localparam logic [8:0]  LP_EP = 9'(V_RES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_IGNORE, ST_CASET, ST_PASET, ST_RAMWR
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cs_s1, r_cs_s2, r_wr_s1, r_wr_s2, r_wr_s3, r_rs_s1, r_rs_s2;
    logic [15:0] r_data_s1, r_data_s2;
    logic [23:0] r_param;
    logic [1:0]  r_pcnt;
    logic [8:0]  r_sc, r_ec, r_sp, r_ep, r_ptr_x, r_ptr_y;
    logic        r_overflow, r_cmd_err;
    logic [33:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic        r_head_vld;

    logic        w_strobe, w_cmd, w_dat;
    logic [31:0] w_word;
    logic [15:0] w_start, w_end;
    logic        w_push, w_pop, w_full, w_acc, w_drop;
    logic        w_ld_ptr, w_swreset, w_set_col, w_set_row, w_err_set;
    logic        w_param_clr, w_param_shift;
    logic [33:0] w_head;
    logic        w_unused_rd;

    // Reads are unsupported; rd is deliberately left unobserved.
    assign w_unused_rd = bus.lt24_rd;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_wr_s1   <= 1'b1;
            r_wr_s2   <= 1'b1;
            r_wr_s3   <= 1'b1;
            r_rs_s1   <= 1'b0;
            r_rs_s2   <= 1'b0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_cs_s1   <= bus.lt24_cs;
            r_cs_s2   <= r_cs_s1;
            r_wr_s1   <= bus.lt24_wr;
            r_wr_s2   <= r_wr_s1;
            r_wr_s3   <= r_wr_s2;
            r_rs_s1   <= bus.lt24_rs;
            r_rs_s2   <= r_rs_s1;
            r_data_s1 <= bus.lt24_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_strobe = r_wr_s2 & ~r_wr_s3 & ~r_cs_s2;
    assign w_cmd    = w_strobe & ~r_rs_s2;
    assign w_dat    = w_strobe & r_rs_s2;
    assign w_word   = {r_param, r_data_s2[7:0]};
    assign w_start  = w_word[31:16];
    assign w_end    = w_word[15:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ld_ptr      = 1'b0;
        w_swreset     = 1'b0;
        w_set_col     = 1'b0;
        w_set_row     = 1'b0;
        w_err_set     = 1'b0;
        w_push        = 1'b0;
        w_param_clr   = 1'b0;
        w_param_shift = 1'b0;
        if (w_cmd) begin
            w_param_clr = 1'b1;
            case (r_data_s2[7:0])
                8'h2A:   w_state_nxt = ST_CASET;
                8'h2B:   w_state_nxt = ST_PASET;
                8'h2C: begin
                    w_state_nxt = ST_RAMWR;
                    w_ld_ptr    = 1'b1;
                end
                8'h3C:   w_state_nxt = ST_RAMWR;
                8'h01: begin
                    w_state_nxt = ST_IDLE;
                    w_swreset   = 1'b1;
                end
                default: w_state_nxt = ST_IGNORE;
            endcase
        end else if (w_dat) begin
            case (r_state)
                ST_CASET, ST_PASET: begin
                    if (r_pcnt == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                        w_param_clr = 1'b1;
                        if (r_state == ST_CASET) begin
                            if (w_start <= w_end && w_end < LP_H) w_set_col = 1'b1;
                            else                                  w_err_set = 1'b1;
                        end else begin
                            if (w_start <= w_end && w_end < LP_V) w_set_row = 1'b1;
                            else                                  w_err_set = 1'b1;
                        end
                    end else begin
                        w_param_shift = 1'b1;
                    end
                end
                ST_RAMWR: w_push = 1'b1;
                default: ;
            endcase
        end else if (r_cs_s2 && (r_state == ST_CASET || r_state == ST_PASET)) begin
            // Deselect abandons a half-collected window; RAMWR survives deselect.
            w_state_nxt = ST_IDLE;
            w_param_clr = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sc       <= '0;
            r_ec       <= LP_EC;
            r_sp       <= '0;
            r_ep       <= LP_EP;
            r_ptr_x    <= '0;
            r_ptr_y    <= '0;
            r_param    <= '0;
            r_pcnt     <= '0;
            r_overflow <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            if (w_param_clr) begin
                r_pcnt <= '0;
            end else if (w_param_shift) begin
                r_pcnt  <= r_pcnt + 2'd1;
                r_param <= {r_param[15:0], r_data_s2[7:0]};
            end
            if (w_swreset) begin
                r_sc <= '0;
                r_ec <= LP_EC;
                r_sp <= '0;
                r_ep <= LP_EP;
            end else if (w_set_col) begin
                r_sc <= w_start[8:0];
                r_ec <= w_end[8:0];
            end else if (w_set_row) begin
                r_sp <= w_start[8:0];
                r_ep <= w_end[8:0];
            end
            if (w_swreset) begin
                r_ptr_x <= '0;
                r_ptr_y <= '0;
            end else if (w_ld_ptr) begin
                r_ptr_x <= r_sc;
                r_ptr_y <= r_sp;
            end else if (w_push) begin
                if (r_ptr_x < r_ec) begin
                    r_ptr_x <= r_ptr_x + 9'd1;
                end else begin
                    r_ptr_x <= r_sc;
                    r_ptr_y <= (r_ptr_y < r_ep) ? r_ptr_y + 9'd1 : r_sp;
                end
            end
            if (w_err_set) r_cmd_err  <= 1'b1;
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

    assign w_pop  = r_head_vld & bus.pix_ready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_acc  = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_comb begin
        case ({w_acc, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) r_mem[r_wptr] <= {r_ptr_x, r_ptr_y, r_data_s2};
    end

    // Head visibility lags a fresh push by one cycle; entries already queued show at once after a pop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_head_vld <= 1'b0;
        end else begin
            if (w_acc) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count    <= w_count_nxt;
            r_head_vld <= ((r_count - CW'(w_pop)) != '0);
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign bus.pix_valid  = r_head_vld;
    assign bus.pix_x      = r_head_vld ? w_head[33:25] : 9'd0;
    assign bus.pix_y      = r_head_vld ? w_head[24:16] : 9'd0;
    assign bus.pix_data   = r_head_vld ? w_head[15:0]  : 16'd0;
    assign o_ramwr_active = (r_state == ST_RAMWR);
    assign o_overflow     = r_overflow;
    assign o_cmd_err      = r_cmd_err;
endmodule

// File: tb/tb_lt24_panel_receiver.sv
// Bench for lt24_panel_receiver: bus-write vector table plus scoreboard of expected pixels.
module tb_lt24_panel_receiver;
    logic clk = 1'b0;
    logic rst;
    logic ramwr, ovf, cerr;
    int   n_checks = 0;
    int   n_fail   = 0;

    lt24_panel_receiver_if bus ();

    lt24_panel_receiver #(.H_RES(240), .V_RES(320), .FIFO_DEPTH(4)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .bus            (bus),
        .o_ramwr_active (ramwr),
        .o_overflow     (ovf),
        .o_cmd_err      (cerr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rs;
        logic [15:0] dat;
        logic        pix;
        logic [8:0]  ex;
        logic [8:0]  ey;
    } vec_t;

    localparam int NV = 33;
    vec_t        vt [NV];
    logic [33:0] q [$];

    function automatic vec_t mk(input logic rs, input logic [15:0] d,
                                input logic p, input int x, input int y);
        vec_t v;
        v.rs = rs; v.dat = d; v.pix = p; v.ex = 9'(x); v.ey = 9'(y);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic rs, input logic [15:0] d);
        bus.lt24_cs   = 1'b0;
        bus.lt24_rs   = rs;
        bus.lt24_data = d;
        bus.lt24_wr   = 1'b0;
        repeat (4) tick();
        bus.lt24_wr   = 1'b1;
        repeat (4) tick();
    endtask

    task automatic expect_wr(input logic [15:0] d, input int x, input int y);
        q.push_back({9'(x), 9'(y), d});
        bus_wr(1'b1, d);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vt[i].pix) q.push_back({vt[i].ex, vt[i].ey, vt[i].dat});
            bus_wr(vt[i].rs, vt[i].dat);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: drain timeout, %0d pixels still expected", nm, q.size());
            q.delete();
        end
        repeat (10) tick();
    endtask

    // Scoreboard: every accepted head pixel must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.pix_valid && bus.pix_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pixel: got (%0d,%0d,%h), expected none",
                         bus.pix_x, bus.pix_y, bus.pix_data);
            end else begin
                logic [33:0] e;
                e = q.pop_front();
                if ({bus.pix_x, bus.pix_y, bus.pix_data} !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d,%h), expected (%0d,%0d,%h)",
                             bus.pix_x, bus.pix_y, bus.pix_data, e[33:25], e[24:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        logic [8:0]  hx, hy;
        logic [15:0] hd;

        // Default window stream, then NOP leaves RAMWR and data is ignored
        vt[0]  = mk(0, 16'h002C, 0, 0, 0);
        vt[1]  = mk(1, 16'hF800, 1, 0, 0);
        vt[2]  = mk(1, 16'h07E0, 1, 1, 0);
        vt[3]  = mk(1, 16'h001F, 1, 2, 0);
        vt[4]  = mk(0, 16'h0000, 0, 0, 0);
        vt[5]  = mk(1, 16'h1234, 0, 0, 0);
        // Window 10..11 x 5..6 with wrap to origin
        vt[6]  = mk(0, 16'h002A, 0, 0, 0);
        vt[7]  = mk(1, 16'h0000, 0, 0, 0);
        vt[8]  = mk(1, 16'h000A, 0, 0, 0);
        vt[9]  = mk(1, 16'h0000, 0, 0, 0);
        vt[10] = mk(1, 16'h000B, 0, 0, 0);
        vt[11] = mk(0, 16'h002B, 0, 0, 0);
        vt[12] = mk(1, 16'h0000, 0, 0, 0);
        vt[13] = mk(1, 16'h0005, 0, 0, 0);
        vt[14] = mk(1, 16'h0000, 0, 0, 0);
        vt[15] = mk(1, 16'h0006, 0, 0, 0);
        vt[16] = mk(0, 16'h002C, 0, 0, 0);
        vt[17] = mk(1, 16'hA000, 1, 10, 5);
        vt[18] = mk(1, 16'hA001, 1, 11, 5);
        vt[19] = mk(1, 16'hA002, 1, 10, 6);
        vt[20] = mk(1, 16'hA003, 1, 11, 6);
        vt[21] = mk(1, 16'hA004, 1, 10, 5);
        // SWRESET, invalid CASET 256..239
        vt[22] = mk(0, 16'h0001, 0, 0, 0);
        vt[23] = mk(0, 16'h002A, 0, 0, 0);
        vt[24] = mk(1, 16'h0001, 0, 0, 0);
        vt[25] = mk(1, 16'h0000, 0, 0, 0);
        vt[26] = mk(1, 16'h0000, 0, 0, 0);
        vt[27] = mk(1, 16'h00EF, 0, 0, 0);
        // RAMWR two pixels, RAMWRC continues
        vt[28] = mk(0, 16'h002C, 0, 0, 0);
        vt[29] = mk(1, 16'hC000, 1, 0, 0);
        vt[30] = mk(1, 16'hC001, 1, 1, 0);
        vt[31] = mk(0, 16'h003C, 0, 0, 0);
        vt[32] = mk(1, 16'hC002, 1, 2, 0);

        rst           = 1'b1;
        bus.lt24_cs   = 1'b1;
        bus.lt24_rs   = 1'b0;
        bus.lt24_wr   = 1'b1;
        bus.lt24_rd   = 1'b1;
        bus.lt24_data = 16'h0000;
        bus.pix_ready = 1'b1;
        repeat (5) tick();
        chk("reset_pix_valid", 32'(bus.pix_valid), 0);
        chk("reset_ramwr",     32'(ramwr), 0);
        chk("reset_overflow",  32'(ovf), 0);
        chk("reset_cmd_err",   32'(cerr), 0);
        chk("reset_pix_bus",   {bus.pix_x[7:0], bus.pix_y[7:0], bus.pix_data}, 0);
        rst = 1'b0;
        repeat (5) tick();

        apply(0, 3);
        wait_drain("t1_drain");
        chk("t1_ramwr_open", 32'(ramwr), 1);
        apply(4, 4);
        chk("t1_ramwr_closed", 32'(ramwr), 0);
        apply(5, 5);
        wait_drain("t1_ignore");

        apply(6, 21);
        wait_drain("t2_drain");
        chk("t2_overflow", 32'(ovf), 0);
        chk("t2_cmd_err",  32'(cerr), 0);

        apply(22, 27);
        chk("t3_cmd_err", 32'(cerr), 1);
        apply(28, 32);
        wait_drain("t3_drain");
        chk("t3_ramwrc_active", 32'(ramwr), 1);

        // Backpressure: 4 held, 2 dropped, pointer still advanced
        bus_wr(1'b0, 16'h0001);
        bus.pix_ready = 1'b0;
        bus_wr(1'b0, 16'h002C);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) q.push_back({9'(i), 9'd0, 16'h0100 + 16'(i)});
            bus_wr(1'b1, 16'h0100 + 16'(i));
        end
        repeat (4) tick();
        chk("t4_head_valid", 32'(bus.pix_valid), 1);
        hx = bus.pix_x; hy = bus.pix_y; hd = bus.pix_data;
        chk("t4_head", {hx[7:0], hy[7:0], hd}, 32'h0000_0100);
        repeat (10) tick();
        chk("t4_head_stable", {bus.pix_x[7:0], bus.pix_y[7:0], bus.pix_data}, 32'h0000_0100);
        chk("t4_overflow", 32'(ovf), 1);
        bus.pix_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_empty", 32'(bus.pix_valid), 0);
        expect_wr(16'h0106, 6, 0);
        wait_drain("t4_7th");

        // Partial CASET cancelled by deselect; page window 0..0 only
        bus_wr(1'b0, 16'h0001);
        bus_wr(1'b0, 16'h002A);
        bus_wr(1'b1, 16'h0000);
        bus_wr(1'b1, 16'h0005);
        bus.lt24_cs = 1'b1;
        repeat (6) tick();
        bus.lt24_cs = 1'b0;
        repeat (4) tick();
        bus_wr(1'b1, 16'h0000);
        bus_wr(1'b1, 16'h0007);
        bus_wr(1'b0, 16'h002B);
        for (int i = 0; i < 4; i++) bus_wr(1'b1, 16'h0000);
        bus_wr(1'b0, 16'h002C);
        for (int i = 0; i < 241; i++) expect_wr(16'(16'h2000 + i), i % 240, 0);
        wait_drain("t5_drain");
        bus_wr(1'b0, 16'h0001);
        bus_wr(1'b0, 16'h003C);
        expect_wr(16'h5A5A, 0, 0);
        expect_wr(16'h5A5B, 1, 0);
        wait_drain("t5_swreset");

        // Reset mid-stream with 3 queued entries
        bus.pix_ready = 1'b0;
        bus_wr(1'b0, 16'h0001);
        bus_wr(1'b0, 16'h002C);
        for (int i = 0; i < 3; i++) bus_wr(1'b1, 16'h0300 + 16'(i));
        repeat (3) tick();
        chk("t6_pre_valid", 32'(bus.pix_valid), 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(bus.pix_valid), 0);
        chk("t6_rst_ramwr", 32'(ramwr), 0);
        chk("t6_rst_ovf",   32'(ovf), 0);
        chk("t6_rst_err",   32'(cerr), 0);
        rst = 1'b0;
        bus.pix_ready = 1'b1;
        repeat (3) tick();
        bus_wr(1'b1, 16'h0400);
        bus_wr(1'b1, 16'h0401);
        repeat (10) tick();
        chk("t6_no_pixels", 32'(bus.pix_valid), 0);
        bus_wr(1'b0, 16'h002C);
        expect_wr(16'hBEEF, 0, 0);
        wait_drain("t6_drain");
        chk("final_queue_empty", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
